// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares a single 32-bit ripple-carry adder among NUM_REQ requesters.
//   Requesters are granted round-robin. The winning operands are latched,
//   held on the adder for SETTLE_CYCLES clocks so the carry chain settles,
//   and the captured result is returned on one valid/ready response port
//   tagged with the owning requester id.
//
// Ports
//   clk           in   rising-edge clock
//   reset_n       in   synchronous active-low reset
//   req_valid     in   [NUM_REQ]     per-requester operand valid
//   req_ready     out  [NUM_REQ]     per-requester accept (one-hot or zero, combinational)
//   req_a         in   [32*NUM_REQ]  operand a, requester i at [32*i +: 32]
//   req_b         in   [32*NUM_REQ]  operand b, same packing
//   rsp_valid     out               result valid
//   rsp_ready     in                result accept
//   rsp_id        out  [ID_W]       requester that owns the result
//   rsp_sum       out  [32]         a + b modulo 2^32
//   rsp_carryout  out               unsigned carry out of bit 31
//   rsp_overflow  out               two's-complement overflow
//   busy          out               high whenever the FSM is not idle

module adder_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned ID_W          = 2,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_sum,
  output logic                    rsp_carryout,
  output logic                    rsp_overflow,
  output logic                    busy
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  // Counter value on which the settled adder output is captured.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              state_q;
  logic [ID_W-1:0]     rr_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [ID_W-1:0]     op_id_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W-1:0]   rsp_sum_q;
  logic                rsp_carry_q;
  logic                rsp_ovf_q;
  logic                busy_q;

  // ---------------------------------------------------------------------------
  // Next-state helpers
  // ---------------------------------------------------------------------------
  logic                grant_found;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     rr_ptr_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;

  // Datapath nets
  logic [DATA_W:0]     carry_c;
  logic [DATA_W-1:0]   sum_c;
  logic                overflow_c;

  // ---------------------------------------------------------------------------
  // Round-robin pick: first pass covers rr_ptr..NUM_REQ-1, second pass wraps
  // to 0..rr_ptr-1 (only reached when the first pass found nothing).
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i] && (i >= int'(rr_ptr_q))) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(i);
      end
    end
  end

  // Pointer moves one past the winner so it has lowest priority next time.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_found) begin
      if (grant_idx >= ID_W'(NUM_REQ - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + ID_W'(1);
      end
    end
  end

  // Accept is only offered while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (reset_n && (state_q == S_IDLE) && grant_found) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        req_ready[i] = (grant_idx == ID_W'(i));
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Settle counter advances every cycle spent in SETTLE.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_SETTLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Shared 32-bit ripple-carry adder, carry-in tied low.
  // ---------------------------------------------------------------------------
  assign carry_c[0] = 1'b0;

  for (genvar g = 0; g < DATA_W; g++) begin : g_ripple
    assign sum_c[g]       = op_a_q[g] ^ op_b_q[g] ^ carry_c[g];
    assign carry_c[g + 1] = (op_a_q[g] & op_b_q[g]) |
                            (carry_c[g] & (op_a_q[g] ^ op_b_q[g]));
  end

  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign overflow_c = carry_c[DATA_W-1] ^ carry_c[DATA_W];

  // ---------------------------------------------------------------------------
  // Control FSM: IDLE -> SETTLE -> RESP -> IDLE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (grant_found) begin
            op_a_q   <= sel_a;
            op_b_q   <= sel_b;
            op_id_q  <= grant_idx;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          cnt_q <= cnt_d;
          if (cnt_q == SETTLE_LAST) begin
            rsp_sum_q   <= sum_c;
            rsp_carry_q <= carry_c[DATA_W];
            rsp_ovf_q   <= overflow_c;
            rsp_id_q    <= op_id_q;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end
        end

        S_RESP: begin
          // Response payload stays put until the consumer takes it; the
          // return to IDLE costs one cycle before the next grant.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_sum      = rsp_sum_q;
  assign rsp_carryout = rsp_carry_q;
  assign rsp_overflow = rsp_ovf_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
//   Self-checking bench for adder_arbiter. Expected results are computed by a
//   behavioural 33-bit addition model and queued on accept; responses are
//   popped and compared as they come out.

module tb_adder_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned DW      = 32;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   sum;
    logic            co;
    logic            ov;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [DW*NUM_REQ-1:0]  req_a;
  logic [DW*NUM_REQ-1:0]  req_b;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [DW-1:0]          rsp_sum;
  logic                   rsp_carryout;
  logic                   rsp_overflow;
  logic                   busy;

  logic [DW-1:0] a_arr [NUM_REQ];
  logic [DW-1:0] b_arr [NUM_REQ];

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_pack
    assign req_a[g*DW +: DW] = a_arr[g];
    assign req_b[g*DW +: DW] = b_arr[g];
  end

  adder_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .ID_W          (ID_W),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_sum      (rsp_sum),
    .rsp_carryout (rsp_carryout),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  function automatic exp_t model(input logic [ID_W-1:0] id, input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] w;
    exp_t r;
    w     = {1'b0, a} + {1'b0, b};
    r.id  = id;
    r.sum = w[DW-1:0];
    r.co  = w[DW];
    r.ov  = (a[DW-1] == b[DW-1]) && (w[DW-1] != a[DW-1]);
    return r;
  endfunction

  // Present a request and wait for its accept; returns at the negedge after the accept edge.
  task automatic issue(input logic [ID_W-1:0] idx, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       output int acc_cyc, output bit ok);
    a_arr[idx]     = a;
    b_arr[idx]     = b;
    req_valid[idx] = 1'b1;
    ok      = 1'b0;
    acc_cyc = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      #1;
      if (req_ready[idx]) begin
        sb.push_back(model(idx, a, b));
        @(negedge clk);
        acc_cyc        = cyc;
        req_valid[idx] = 1'b0;
        ok             = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) req_valid[idx] = 1'b0;
  endtask

  // Wait for a response with rsp_ready high; returns at the negedge after the handshake.
  task automatic collect(output exp_t got, output int seen_cyc, output bit ok);
    rsp_ready = 1'b1;
    ok        = 1'b0;
    got       = '0;
    seen_cyc  = 0;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (rsp_valid) begin
        got.id   = rsp_id;
        got.sum  = rsp_sum;
        got.co   = rsp_carryout;
        got.ov   = rsp_overflow;
        seen_cyc = cyc;
        ok       = 1'b1;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = 32'hA5A5_0000 + i;
      b_arr[i] = 32'h0000_1111;
    end
    req_valid = '1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    n_tests++;
    if ({rsp_valid, busy, rsp_id, rsp_sum, rsp_carryout, rsp_overflow} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b busy=%b id=%0d sum=%h co=%b ov=%b want all 0",
               rsp_valid, busy, rsp_id, rsp_sum, rsp_carryout, rsp_overflow);
    end
    req_valid = '0;
    reset_n   = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_idle: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_basic();
    exp_t got, e;
    int   acc, seen;
    bit   ok, ok2;
    rsp_ready = 1'b1;
    issue(2'd0, 32'h1, 32'h1, acc, ok);
    n_tests++;
    if (ok !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL basic_accept: got accepted=%b busy=%b want 1 1", ok, busy);
    end
    collect(got, seen, ok2);
    n_tests++;
    if (!ok2 || sb.size() == 0) begin
      n_fail++; $display("FAIL basic_rsp: got no response (queued=%0d) want one", sb.size());
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL basic_rsp: got id=%0d sum=%h co=%b ov=%b want id=%0d sum=%h co=%b ov=%b",
                 got.id, got.sum, got.co, got.ov, e.id, e.sum, e.co, e.ov);
      end
    end
    n_tests++;
    if (seen - acc !== int'(SETTLE)) begin
      n_fail++; $display("FAIL basic_latency: got %0d want %0d", seen - acc, SETTLE);
    end
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00 || rsp_sum !== 32'h2) begin
      n_fail++;
      $display("FAIL basic_after_hs: got valid=%b busy=%b sum=%h want 0 0 00000002", rsp_valid, busy, rsp_sum);
    end
  endtask

  task automatic test_carry_overflow();
    exp_t got, e;
    int   acc, seen;
    bit   ok, ok2;
    logic [ID_W-1:0] ids [2];
    logic [DW-1:0]   as  [2];
    logic [DW-1:0]   bs  [2];
    ids[0] = 2'd2; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h0000_0001;
    ids[1] = 2'd1; as[1] = 32'h7FFF_FFFF; bs[1] = 32'h0000_0002;
    for (int k = 0; k < 2; k++) begin
      issue(ids[k], as[k], bs[k], acc, ok);
      collect(got, seen, ok2);
      n_tests++;
      if (!ok || !ok2 || sb.size() == 0) begin
        n_fail++; $display("FAIL carry_ovf_%0d: got accepted=%b rsp=%b want 1 1", k, ok, ok2);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL carry_ovf_%0d: got id=%0d sum=%h co=%b ov=%b want id=%0d sum=%h co=%b ov=%b",
                   k, got.id, got.sum, got.co, got.ov, e.id, e.sum, e.co, e.ov);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t got, e;
    int   seen;
    bit   found, ok2;
    logic [ID_W-1:0]    want;
    logic [NUM_REQ-1:0] want_vec;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = 32'h100 + i;
      b_arr[i] = 32'h0;
    end
    req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      want     = ID_W'(k % NUM_REQ);
      want_vec = NUM_REQ'(1) << want;
      found    = 1'b0;
      for (int n = 0; n < 50; n++) begin
        #1;
        if (req_ready != '0) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      n_tests++;
      if (!found || req_ready !== want_vec) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, want_vec);
      end
      sb.push_back(model(want, a_arr[want], b_arr[want]));
      @(negedge clk);
      a_arr[want] = 32'h200 + 32'(want);
      collect(got, seen, ok2);
      n_tests++;
      if (!ok2 || sb.size() == 0) begin
        n_fail++; $display("FAIL rr_rsp_%0d: got no response want one", k);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL rr_rsp_%0d: got id=%0d sum=%h want id=%0d sum=%h", k, got.id, got.sum, e.id, e.sum);
        end
      end
    end
    req_valid = '0;
  endtask

  task automatic test_backpressure();
    exp_t got, e;
    int   acc;
    bit   ok, seen_v;
    rsp_ready = 1'b0;
    issue(2'd1, 32'h0000_1234, 32'h0000_0010, acc, ok);
    a_arr[3] = 32'h3;
    b_arr[3] = 32'h3;
    req_valid[3] = 1'b1;
    seen_v = 1'b0;
    for (int n = 0; n < 50 && !seen_v; n++) begin
      if (rsp_valid) seen_v = 1'b1;
      else @(negedge clk);
    end
    got = '{id: rsp_id, sum: rsp_sum, co: rsp_carryout, ov: rsp_overflow};
    n_tests++;
    if (!ok || !seen_v || sb.size() == 0) begin
      n_fail++; $display("FAIL bp_rsp: got accepted=%b valid=%b want 1 1", ok, seen_v);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_fail++; $display("FAIL bp_rsp: got id=%0d sum=%h want id=%0d sum=%h", got.id, got.sum, e.id, e.sum);
      end
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== '0 ||
          {rsp_id, rsp_sum, rsp_carryout, rsp_overflow} !== got) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%b busy=%b ready=%b id=%0d sum=%h want 1 1 0000 id=%0d sum=%h",
                 k, rsp_valid, busy, req_ready, rsp_id, rsp_sum, got.id, got.sum);
      end
    end
    req_valid[3] = 1'b0;
    rsp_ready    = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({rsp_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL bp_release: got valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
    @(negedge clk);
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_single_hs: got valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid();
    exp_t got, e;
    int   acc, seen;
    bit   ok, ok2;
    logic [ID_W-1:0] order [2];
    rsp_ready = 1'b1;
    issue(2'd2, 32'hDEAD_0000, 32'h0000_BEEF, acc, ok);
    if (sb.size() != 0) void'(sb.pop_back());
    reset_n      = 1'b0;
    a_arr[1]     = 32'h11;  b_arr[1] = 32'h1;
    a_arr[3]     = 32'h33;  b_arr[3] = 32'h1;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL rmid_ready_in_reset: got %b want 0000", req_ready);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_tests++;
      if ({rsp_valid, busy, rsp_id, rsp_sum, rsp_carryout, rsp_overflow} !== '0) begin
        n_fail++;
        $display("FAIL rmid_outputs_%0d: got valid=%b busy=%b id=%0d sum=%h want all 0",
                 k, rsp_valid, busy, rsp_id, rsp_sum);
      end
    end
    reset_n = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++; $display("FAIL rmid_first_grant: got %b want 0010", req_ready);
    end
    order[0] = 2'd1;
    order[1] = 2'd3;
    for (int k = 0; k < 2; k++) begin
      issue(order[k], a_arr[order[k]], b_arr[order[k]], acc, ok);
      collect(got, seen, ok2);
      n_tests++;
      if (!ok || !ok2 || sb.size() == 0) begin
        n_fail++; $display("FAIL rmid_rsp_%0d: got accepted=%b rsp=%b want 1 1", k, ok, ok2);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++; $display("FAIL rmid_rsp_%0d: got id=%0d sum=%h want id=%0d sum=%h", k, got.id, got.sum, e.id, e.sum);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t got, e;
    int   acc1, acc2, seen;
    bit   ok, ok2, seen_v;
    rsp_ready = 1'b1;
    issue(2'd0, 32'h8000_0000, 32'hFFFF_FFFB, acc1, ok);
    a_arr[1]     = 32'h7FFF_FFFF;
    b_arr[1]     = 32'h7FFF_FFFF;
    req_valid[1] = 1'b1;
    seen_v = 1'b0;
    for (int n = 0; n < 50 && !seen_v; n++) begin
      if (rsp_valid) seen_v = 1'b1;
      else @(negedge clk);
    end
    #1;
    got = '{id: rsp_id, sum: rsp_sum, co: rsp_carryout, ov: rsp_overflow};
    n_tests++;
    if (req_ready !== '0) begin
      n_fail++; $display("FAIL b2b_no_bypass: got %b want 0000", req_ready);
    end
    n_tests++;
    if (!ok || !seen_v || sb.size() == 0) begin
      n_fail++; $display("FAIL b2b_rsp0: got accepted=%b valid=%b want 1 1", ok, seen_v);
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b_rsp0: got sum=%h co=%b ov=%b want sum=%h co=%b ov=%b",
                 got.sum, got.co, got.ov, e.sum, e.co, e.ov);
      end
    end
    @(negedge clk);
    issue(2'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, acc2, ok);
    n_tests++;
    if (!ok || (acc2 - acc1) !== int'(SETTLE + 2)) begin
      n_fail++; $display("FAIL b2b_interval: got %0d want %0d", acc2 - acc1, SETTLE + 2);
    end
    collect(got, seen, ok2);
    n_tests++;
    if (!ok2 || sb.size() == 0) begin
      n_fail++; $display("FAIL b2b_rsp1: got no response want one");
    end else begin
      e = sb.pop_front();
      if (got !== e) begin
        n_fail++;
        $display("FAIL b2b_rsp1: got id=%0d sum=%h co=%b ov=%b want id=%0d sum=%h co=%b ov=%b",
                 got.id, got.sum, got.co, got.ov, e.id, e.sum, e.co, e.ov);
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL b2b_sb_empty: got %0d queued want 0", sb.size());
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    rsp_ready = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    test_reset();
    test_basic();
    test_carry_overflow();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
